ibr128_stream_master: RTL and testbench

IBR128_STREAM_MASTER -- requirements
Module: ibr128_stream_master

---
 rtl/ibr128_stream_master.sv | 227 ++++++++++++++++++++++
 tb/tb_ibr128_stream_master.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibr128_stream_master.sv
// ibr128_stream_master: gathers 4x32-bit stream words into a 128-bit block.
// It writes the block to a CSR-mapped cipher core, starts the core, polls it
// until done and reads back the ciphertext, then streams that out LSW first.
module ibr128_stream_master #(
    parameter logic [4:0]  CTRL_ADDR = 5'h00,
    parameter logic [4:0]  STAT_ADDR = 5'h01,
    parameter logic [4:0]  PT_ADDR   = 5'h04,
    parameter logic [4:0]  CT_ADDR   = 5'h0C,
    parameter logic [31:0] CTRL_GO   = 32'h0000_0005,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic        CS,
    output logic        Write,
    output logic        Read,
    output logic [4:0]  Addr,
    output logic [31:0] WData,
    input  logic [31:0] RData,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        busy,
    output logic        err
);

    localparam int unsigned PW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_FILL,
        S_WRITE,
        S_START,
        S_POLL,
        S_POLL_WAIT,
        S_READ,
        S_READ_WAIT,
        S_CLEAR,
        S_DRAIN
    } state_e;

    // One CSR bus command; all-zero means the bus is idle.
    typedef struct packed {
        logic        cs;
        logic        we;
        logic        re;
        logic [4:0]  addr;
        logic [31:0] wdata;
    } csr_t;

    state_e        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [PW-1:0] poll_q, poll_d;
    logic          err_q, err_d;
    logic          tmo_q, tmo_d;
    logic [31:0]   slot_q [4];
    logic [31:0]   slot_d [4];

    csr_t          bus_q, bus_d;
    logic          s_ready_q, s_ready_d;
    logic          m_valid_q, m_valid_d;
    logic [31:0]   m_data_q, m_data_d;
    logic          busy_q, busy_d;

    // Next-state logic: block sequencing, slot storage, poll count and timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        poll_d  = poll_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        slot_d  = slot_q;
        unique case (state_q)
            S_FILL: begin
                if (s_valid) begin
                    slot_d[cnt_q] = s_data;
                    cnt_d         = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                        poll_d  = '0;
                        tmo_d   = 1'b0;
                    end
                end
            end
            S_WRITE: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_POLL;
            end
            S_POLL: begin
                poll_d  = poll_q + PW'(1);
                state_d = S_POLL_WAIT;
            end
            S_POLL_WAIT: begin
                if (RData[0]) begin
                    state_d = S_READ;
                    cnt_d   = 2'd0;
                end else if (poll_q == PW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = S_CLEAR;
                end else begin
                    state_d = S_POLL;
                end
            end
            S_READ: begin
                state_d = S_READ_WAIT;
            end
            S_READ_WAIT: begin
                slot_d[cnt_q] = RData;
                cnt_d         = cnt_q + 2'd1;
                state_d       = (cnt_q == 2'd3) ? S_CLEAR : S_READ;
            end
            S_CLEAR: begin
                cnt_d   = 2'd0;
                state_d = tmo_q ? S_FILL : S_DRAIN;
            end
            S_DRAIN: begin
                if (m_ready) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_FILL;
                    end
                end
            end
            default: begin
                state_d = S_FILL;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // Output decode from the upcoming state so every port comes straight off a flop.
    always_comb begin
        bus_d     = '0;
        s_ready_d = 1'b0;
        m_valid_d = 1'b0;
        m_data_d  = 32'h0;
        busy_d    = (state_d != S_FILL);
        unique case (state_d)
            S_FILL: begin
                s_ready_d = 1'b1;
            end
            S_WRITE: begin
                bus_d.cs    = 1'b1;
                bus_d.we    = 1'b1;
                bus_d.addr  = PT_ADDR + 5'(cnt_d);
                bus_d.wdata = slot_d[cnt_d];
            end
            S_START: begin
                bus_d.cs    = 1'b1;
                bus_d.we    = 1'b1;
                bus_d.addr  = CTRL_ADDR;
                bus_d.wdata = CTRL_GO;
            end
            S_POLL: begin
                bus_d.cs   = 1'b1;
                bus_d.re   = 1'b1;
                bus_d.addr = STAT_ADDR;
            end
            S_READ: begin
                bus_d.cs   = 1'b1;
                bus_d.re   = 1'b1;
                bus_d.addr = CT_ADDR + 5'(cnt_d);
            end
            S_CLEAR: begin
                bus_d.cs   = 1'b1;
                bus_d.we   = 1'b1;
                bus_d.addr = CTRL_ADDR;
            end
            S_DRAIN: begin
                m_valid_d = 1'b1;
                m_data_d  = slot_d[cnt_d];
            end
            default: begin
                bus_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= S_FILL;
            cnt_q     <= 2'd0;
            poll_q    <= '0;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
            slot_q    <= '{default: 32'h0};
            bus_q     <= '0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            m_data_q  <= 32'h0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            poll_q    <= poll_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            slot_q    <= slot_d;
            bus_q     <= bus_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            busy_q    <= busy_d;
        end
    end

    assign CS      = bus_q.cs;
    assign Write   = bus_q.we;
    assign Read    = bus_q.re;
    assign Addr    = bus_q.addr;
    assign WData   = bus_q.wdata;
    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign busy    = busy_q;
    assign err     = err_q;

endmodule

// File: tb/tb_ibr128_stream_master.sv
// Bench for ibr128_stream_master: a CSR cipher-core model answers the bus, a
// block-level model predicts bus transactions and output words, and a negedge
// monitor compares the DUT against it every cycle.
module tb_ibr128_stream_master;

    localparam logic [4:0]  CTRL_A = 5'h00;
    localparam logic [4:0]  STAT_A = 5'h01;
    localparam logic [4:0]  PT_A   = 5'h04;
    localparam logic [4:0]  CT_A   = 5'h0C;
    localparam logic [31:0] GO     = 32'h0000_0005;
    localparam int          TMO    = 8;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        s_valid, s_ready;
    logic [31:0] s_data;
    logic        CS, Write, Read;
    logic [4:0]  Addr;
    logic [31:0] WData, RData;
    logic        m_valid, m_ready;
    logic [31:0] m_data;
    logic        busy, err;

    ibr128_stream_master #(
        .CTRL_ADDR(CTRL_A), .STAT_ADDR(STAT_A), .PT_ADDR(PT_A), .CT_ADDR(CT_A),
        .CTRL_GO(GO), .TIMEOUT(TMO)
    ) dut (
        .Clk(Clk), .Rst(Rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .CS(CS), .Write(Write), .Read(Read), .Addr(Addr), .WData(WData), .RData(RData),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy), .err(err)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } txn_t;

    int n_vec = 0;
    int n_err = 0;

    // Stimulus / model state
    logic [31:0] in_q[$];
    int          ra_model_q[$];
    int          ra_periph_q[$];
    txn_t        exp_bus[$];
    logic [31:0] exp_out[$];
    bit          exp_err = 1'b0;
    bit          in_acc = 1'b0;
    int          valid_pct = 100;
    int          mr_mode = 0;

    // Monitor bookkeeping
    int          cyc = 0;
    logic [31:0] col [4];
    int          col_n = 0;
    int          acc4_cyc = 0, last_lat = -1;
    int          last_out4_cyc = 0, first_gap = -1;
    int          stat_blk = 0, out_total = 0, ob = 0;
    logic [31:0] out_log [4];
    bit          ct1_seen = 1'b0;
    bit          prev_mv = 1'b0, prev_mr = 1'b0;
    logic [31:0] prev_md = 32'h0;
    txn_t        e;

    // Cipher-core model state
    logic [31:0] pt [4];
    logic [31:0] ct [4];
    int          ra_cur = 0, polls_seen = 0;

    function automatic logic [31:0] cipher(input logic [31:0] w, input int k);
        return {w[15:0], w[31:16]} ^ (32'h9E37_79B9 * 32'(k + 1));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
    endtask

    function automatic txn_t mk(input logic we, input logic [4:0] a, input logic [31:0] d);
        txn_t t;
        t.we = we;
        t.addr = a;
        t.data = d;
        return t;
    endfunction

    // Predict the whole bus conversation and output words of one accepted block.
    task automatic model_block();
        int ra, polls;
        bit ok;
        ra = (ra_model_q.size() > 0) ? ra_model_q.pop_front() : 0;
        ok = (ra >= 1 && ra <= TMO);
        polls = ok ? ra : TMO;
        for (int k = 0; k < 4; k++) exp_bus.push_back(mk(1'b1, PT_A + 5'(k), col[k]));
        exp_bus.push_back(mk(1'b1, CTRL_A, GO));
        for (int p = 0; p < polls; p++) exp_bus.push_back(mk(1'b0, STAT_A, 32'h0));
        if (ok) begin
            for (int k = 0; k < 4; k++) begin
                exp_bus.push_back(mk(1'b0, CT_A + 5'(k), 32'h0));
                exp_out.push_back(cipher(col[k], k));
            end
        end else begin
            exp_err = 1'b1;
        end
        exp_bus.push_back(mk(1'b1, CTRL_A, 32'h0));
    endtask

    // CSR cipher core: ready after a per-block number of status polls (0 = never).
    always @(posedge Clk) begin
        if (Rst) begin
            ra_cur = 0;
            polls_seen = 0;
            RData <= 32'h0;
        end else begin
            RData <= $urandom;
            if (CS && Write) begin
                if (Addr >= PT_A && Addr < PT_A + 5'd4) begin
                    pt[int'(Addr - PT_A)] = WData;
                end else if (Addr == CTRL_A) begin
                    if (WData == GO && ra_periph_q.size() > 0) begin
                        ra_cur = ra_periph_q.pop_front();
                        polls_seen = 0;
                        for (int k = 0; k < 4; k++) ct[k] = cipher(pt[k], k);
                    end else begin
                        ra_cur = 0;
                    end
                end
            end
            if (CS && Read) begin
                if (Addr == STAT_A) begin
                    polls_seen++;
                    RData <= {31'h0, (ra_cur != 0 && polls_seen >= ra_cur)};
                end else if (Addr >= CT_A && Addr < CT_A + 5'd4) begin
                    RData <= ct[int'(Addr - CT_A)];
                end
            end
        end
    end

    // Input/backpressure driver, just after each rising edge.
    always @(posedge Clk) begin
        #1;
        if (in_acc) begin
            in_q.delete(0);
            in_acc = 1'b0;
        end
        if (in_q.size() > 0 && (s_valid || $urandom_range(0, 99) < valid_pct)) begin
            s_valid = 1'b1;
            s_data  = in_q[0];
        end else begin
            s_valid = 1'b0;
            s_data  = $urandom;
        end
        case (mr_mode)
            0: m_ready = 1'b1;
            1: m_ready = ~m_ready;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Per-cycle compare against the model.
    always @(negedge Clk) begin
        cyc++;
        if (Rst) begin
            exp_bus.delete();
            exp_out.delete();
            col_n = 0;
            ob = 0;
            exp_err = 1'b0;
            prev_mv = 1'b0;
        end else begin
            chk("rw_excl", 64'(Write & Read), 64'h0);
            if (!CS) chk("idle_bus", 64'({Write, Read, Addr, WData}), 64'h0);
            chk("s_ready_vs_busy", 64'(s_ready), 64'(!busy));
            if (m_valid) chk("m_valid_busy", 64'(busy), 64'h1);
            if (prev_mv && !prev_mr) chk("m_hold", 64'({m_valid, m_data}), 64'({1'b1, prev_md}));
            if (CS) begin
                if (exp_bus.size() == 0) begin
                    fail_now("unexpected_bus");
                end else begin
                    e = exp_bus.pop_front();
                    chk("bus", 64'({Write, Read, Addr, Write ? WData : 32'h0}),
                        64'({e.we, !e.we, e.addr, e.we ? e.data : 32'h0}));
                end
                if (Read && Addr == STAT_A) stat_blk++;
                if (Read && Addr == CT_A + 5'd1) ct1_seen = 1'b1;
            end
            if (s_valid && s_ready) begin
                if (col_n == 0) first_gap = cyc - last_out4_cyc;
                col[col_n] = s_data;
                col_n++;
                in_acc = 1'b1;
                if (col_n == 4) begin
                    col_n = 0;
                    acc4_cyc = cyc;
                    stat_blk = 0;
                    model_block();
                end
            end
            if (m_valid && !prev_mv) last_lat = cyc - acc4_cyc;
            if (m_valid && m_ready) begin
                if (exp_out.size() == 0) begin
                    fail_now("unexpected_out");
                end else begin
                    chk("m_data", 64'(m_data), 64'(exp_out.pop_front()));
                end
                out_log[ob] = m_data;
                ob = (ob + 1) % 4;
                out_total++;
                if (ob == 0) last_out4_cyc = cyc;
            end
            prev_mv = m_valid;
            prev_mr = m_ready;
            prev_md = m_data;
        end
    end

    task automatic push_block(input logic [31:0] w0, w1, w2, w3, input int ra);
        in_q.push_back(w0);
        in_q.push_back(w1);
        in_q.push_back(w2);
        in_q.push_back(w3);
        ra_model_q.push_back(ra);
        ra_periph_q.push_back(ra);
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge Clk);
            done = (in_q.size() == 0 && col_n == 0 && exp_bus.size() == 0 &&
                    exp_out.size() == 0 && !busy);
        end
        if (!done) fail_now({name, "_timeout"});
        @(posedge Clk);
        #1;
    endtask

    int base;

    initial begin
        Rst = 1'b1;
        s_valid = 1'b0;
        s_data = 32'h0;
        m_ready = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        chk("rst_bus", 64'({CS, Write, Read, Addr, WData}), 64'h0);
        chk("rst_stream", 64'({m_valid, m_data, busy, err, s_ready}), 64'h1);
        @(posedge Clk);
        #1;

        // Directed block, ready on 3rd poll.
        mr_mode = 0;
        valid_pct = 100;
        push_block(32'h0302_0100, 32'h0706_0504, 32'h0B0A_0908, 32'h0F0E_0D0C, 3);
        wait_idle("block", 2000);
        chk("block_polls", 64'(stat_blk), 64'd3);
        chk("block_ct0", 64'(out_log[0]), 64'h9F37_7ABB);
        chk("block_ct1", 64'(out_log[1]), 64'h396A_F474);
        chk("block_latency", 64'(last_lat), 64'd21);
        chk("block_outs", 64'(out_total), 64'd4);

        // Minimum latency, ready on first poll.
        push_block($urandom, $urandom, $urandom, $urandom, 1);
        wait_idle("minlat", 2000);
        chk("min_latency", 64'(last_lat), 64'd17);

        // Backpressure with m_ready toggling.
        base = out_total;
        mr_mode = 1;
        push_block($urandom, $urandom, $urandom, $urandom, 2);
        wait_idle("bp", 2000);
        chk("bp_outs", 64'(out_total - base), 64'd4);

        // Timeout: status never ready.
        base = out_total;
        mr_mode = 0;
        push_block($urandom, $urandom, $urandom, $urandom, 0);
        wait_idle("tmo", 2000);
        chk("tmo_polls", 64'(stat_blk), 64'd8);
        chk("tmo_err", 64'(err), 64'h1);
        chk("tmo_no_out", 64'(out_total - base), 64'd0);
        chk("tmo_s_ready", 64'(s_ready), 64'h1);

        // Reset pulse during READ_WAIT.
        ct1_seen = 1'b0;
        push_block($urandom, $urandom, $urandom, $urandom, 1);
        for (int i = 0; i < 500 && !ct1_seen; i++) begin
            @(posedge Clk);
            #1;
        end
        if (!ct1_seen) fail_now("midrst_no_read");
        Rst = 1'b1;
        @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        chk("midrst_state", 64'({CS, m_valid, busy, err, s_ready}), 64'h1);
        @(posedge Clk);
        #1;
        base = out_total;
        push_block($urandom, $urandom, $urandom, $urandom, 1);
        wait_idle("midrst_fresh", 2000);
        chk("midrst_outs", 64'(out_total - base), 64'd4);
        chk("midrst_err", 64'(err), 64'h0);

        // Back-to-back blocks with s_valid held high.
        push_block($urandom, $urandom, $urandom, $urandom, 1);
        push_block($urandom, $urandom, $urandom, $urandom, 2);
        wait_idle("b2b", 3000);
        chk("b2b_gap", 64'(first_gap), 64'd1);

        // Randomized blocks, data, poll delays, valid gaps and backpressure.
        valid_pct = 60;
        mr_mode = 2;
        for (int b = 0; b < 20; b++) begin
            push_block($urandom, $urandom, $urandom, $urandom, int'($urandom_range(0, 10)));
        end
        wait_idle("random", 20000);
        chk("random_err", 64'(err), 64'(exp_err));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
